// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Buffers ALU commands in a FIFO, issues them one at a time to an
//            external combinational ALU and returns results on a response stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_c,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] op_count
);

    localparam int         AW          = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [2:0] c_SEL_ILLEGAL = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO: entry = {a, b, sel}
    // ------------------------------------------------------------------
    logic [10:0]   fifo_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [10:0]   w_head;
    logic [3:0]    w_head_a;
    logic [3:0]    w_head_b;
    logic [2:0]    w_head_sel;

    assign cmd_ready  = (count_q != c_FULL_CNT);
    assign w_push     = cmd_valid & cmd_ready;
    assign w_empty    = (count_q == '0);
    assign w_head     = fifo_mem_q[rd_ptr_q];
    assign w_head_a   = w_head[10:7];
    assign w_head_b   = w_head[6:3];
    assign w_head_sel = w_head[2:0];

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!w_push && w_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue / response FSM
    // ------------------------------------------------------------------
    state_t     state_q,     state_d;
    logic [3:0] alu_a_q,     alu_a_d;
    logic [3:0] alu_b_q,     alu_b_d;
    logic [2:0] alu_sel_q,   alu_sel_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [3:0] rsp_data_q,  rsp_data_d;
    logic       rsp_err_q,   rsp_err_d;
    logic [7:0] op_count_q,  op_count_d;
    logic       w_load_head;

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        op_count_d  = op_count_q;
        w_load_head = 1'b0;
        w_pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                w_load_head = !w_empty;
            end
            S_ISSUE: begin
                rsp_data_d  = alu_c;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    op_count_d  = op_count_q + 8'd1;
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    w_load_head = !w_empty;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An illegal select never reaches the ALU: it answers with an error directly.
        if (w_load_head) begin
            w_pop = 1'b1;
            if (w_head_sel == c_SEL_ILLEGAL) begin
                rsp_data_d  = 4'd0;
                rsp_err_d   = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end else begin
                alu_a_d   = w_head_a;
                alu_b_d   = w_head_b;
                alu_sel_d = w_head_sel;
                state_d   = S_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_sel_q   <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 4'd0;
            rsp_err_q   <= 1'b0;
            op_count_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Directed self-checking bench for alu_cmd_sequencer with an ALU model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_c;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic [7:0] op_count;

    int vectors;
    int miscompares;

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_c     (alu_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (alu_sel)
            3'b000:  alu_c = alu_a & alu_b;
            3'b001:  alu_c = ~(alu_a & alu_b);
            3'b011:  alu_c = alu_a | alu_b;
            3'b111:  alu_c = ~(alu_a | alu_b);
            3'b100:  alu_c = alu_a ^ alu_b;
            3'b010:  alu_c = ~(alu_a ^ alu_b);
            3'b110:  alu_c = alu_a + alu_b;
            default: alu_c = 4'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
    endtask

    initial begin
        int acc;
        int got;
        int seen;
        int hs;
        int cyc;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = 4'd0;
        cmd_b       = 4'd0;
        cmd_sel     = 3'd0;
        rsp_ready   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        check("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        check("rst_op_count", op_count, 8'd0);
        check("rst_alu_sel", {5'd0, alu_sel}, 8'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- single AND ----------------
        rsp_ready = 1'b1;
        drive_cmd(4'hC, 4'hA, 3'b000);
        tick();
        cmd_valid = 1'b0;
        check("and_valid_n1", {7'd0, rsp_valid}, 8'd0);
        tick();
        check("and_alu_sel", {5'd0, alu_sel}, 8'd0);
        check("and_alu_a", {4'd0, alu_a}, 8'h0C);
        check("and_valid_n2_early", {7'd0, rsp_valid}, 8'd0);
        tick();
        check("and_valid", {7'd0, rsp_valid}, 8'd1);
        check("and_data", {4'd0, rsp_data}, 8'h08);
        check("and_err", {7'd0, rsp_err}, 8'd0);
        tick();
        check("and_op_count", op_count, 8'd1);
        check("and_valid_drop", {7'd0, rsp_valid}, 8'd0);

        // ---------------- back-to-back ADD, OR, XOR ----------------
        drive_cmd(4'h9, 4'h8, 3'b110);
        tick();
        drive_cmd(4'h5, 4'h2, 3'b011);
        tick();
        drive_cmd(4'hF, 4'h3, 3'b100);
        tick();
        cmd_valid = 1'b0;
        check("b2b_add_valid", {7'd0, rsp_valid}, 8'd1);
        check("b2b_add_data", {4'd0, rsp_data}, 8'h01);
        tick();
        check("b2b_gap1", {7'd0, rsp_valid}, 8'd0);
        tick();
        check("b2b_or_valid", {7'd0, rsp_valid}, 8'd1);
        check("b2b_or_data", {4'd0, rsp_data}, 8'h07);
        tick();
        check("b2b_gap2", {7'd0, rsp_valid}, 8'd0);
        tick();
        check("b2b_xor_valid", {7'd0, rsp_valid}, 8'd1);
        check("b2b_xor_data", {4'd0, rsp_data}, 8'h0C);
        tick();
        check("b2b_op_count", op_count, 8'd4);
        check("b2b_idle", {7'd0, rsp_valid}, 8'd0);

        // ---------------- stall: fill FIFO ----------------
        rsp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            drive_cmd(4'(k), 4'h1, 3'b110);
            if (cmd_ready) acc++;
            tick();
        end
        cmd_valid = 1'b0;
        check("fill_accepted", 8'(acc), 8'd5);
        check("fill_cmd_ready", {7'd0, cmd_ready}, 8'd0);
        check("stall_valid", {7'd0, rsp_valid}, 8'd1);
        check("stall_data", {4'd0, rsp_data}, 8'h01);
        tick();
        tick();
        check("stall_valid_hold", {7'd0, rsp_valid}, 8'd1);
        check("stall_data_hold", {4'd0, rsp_data}, 8'h01);

        // ---------------- drain ----------------
        rsp_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 40) begin
            if (rsp_valid) begin
                check("drain_data", {4'd0, rsp_data}, 8'(got + 1));
                got++;
            end
            tick();
            cyc++;
        end
        check("drain_count", 8'(got), 8'd5);
        check("drain_op_count", op_count, 8'd9);
        check("drain_idle", {7'd0, rsp_valid}, 8'd0);

        // ---------------- illegal select ----------------
        rsp_ready = 1'b0;
        drive_cmd(4'h3, 4'h3, 3'b101);
        tick();
        drive_cmd(4'hF, 4'h5, 3'b000);
        tick();
        cmd_valid = 1'b0;
        check("ill_valid", {7'd0, rsp_valid}, 8'd1);
        check("ill_data", {4'd0, rsp_data}, 8'h00);
        check("ill_err", {7'd0, rsp_err}, 8'd1);
        check("ill_alu_a_kept", {4'd0, alu_a}, 8'h04);
        check("ill_alu_sel_kept", {5'd0, alu_sel}, 8'h06);
        tick();
        check("ill_hold_err", {7'd0, rsp_err}, 8'd1);
        rsp_ready = 1'b1;
        tick();
        check("post_ill_valid", {7'd0, rsp_valid}, 8'd0);
        check("post_ill_alu_a", {4'd0, alu_a}, 8'h0F);
        check("post_ill_op_count", op_count, 8'd10);
        tick();
        check("post_ill_and_data", {4'd0, rsp_data}, 8'h05);
        check("post_ill_and_err", {7'd0, rsp_err}, 8'd0);
        tick();
        check("post_ill_op_count2", op_count, 8'd11);

        // ---------------- asynchronous reset mid-operation ----------------
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_cmd(4'hF, 4'(k + 1), 3'b000);
            tick();
        end
        cmd_valid = 1'b0;
        check("pre_rst_valid", {7'd0, rsp_valid}, 8'd1);
        check("pre_rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {7'd0, rsp_valid}, 8'd0);
        check("arst_data", {4'd0, rsp_data}, 8'd0);
        check("arst_op_count", op_count, 8'd0);
        check("arst_alu_a", {4'd0, alu_a}, 8'd0);
        check("arst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("no_stale_rsp", 8'(seen), 8'd0);

        // ---------------- op_count wrap ----------------
        hs  = 0;
        cyc = 0;
        drive_cmd(4'h6, 4'h3, 3'b011);
        while (hs < 256 && cyc < 2000) begin
            if (rsp_valid) hs++;
            tick();
            cyc++;
            if (hs == 255 && rsp_valid == 1'b0) begin
                check("wrap_255", op_count, 8'd255);
            end
        end
        check("wrap_hs_256", 8'(hs - 256), 8'd0);
        check("wrap_zero", op_count, 8'd0);
        while (hs < 257 && cyc < 2100) begin
            if (rsp_valid) hs++;
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        check("wrap_one", op_count, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator/driver side of the team's 4-bit combinational ALU interface: operands a, b, 3-bit sel in, 4-bit result c out.
- Accepts ALU commands over a valid/ready stream and buffers them in a small FIFO.
- Issues one command at a time to an external ALU instance, captures the result, and returns it on a valid/ready response stream with an error flag.
- Sits between a command producer (test sequencer or control FSM) and the ALU.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, ≥2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_a  input  4  operand A.
- cmd_b  input  4  operand B.
- cmd_sel  input  3  ALU operation code.
- alu_a  output  4  registered operand A to the ALU.
- alu_b  output  4  registered operand B to the ALU.
- alu_sel  output  3  registered select to the ALU.
- alu_c  input  4  ALU result; combinational from alu_a/alu_b/alu_sel.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  4  captured result.
- rsp_err  output  1  command used an unmapped select.
- op_count  output  8  completed response handshakes, wrapping.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - FIFO emptied, FSM in IDLE.
  - alu_a, alu_b, alu_sel = 0; rsp_valid, rsp_data, rsp_err = 0; op_count = 0.
  - cmd_ready = 1 once reset is held.
  - Reset mid-operation discards all queued and in-flight commands; no response is produced for them.
- Command FIFO:
  - cmd_ready = (occupancy < DEPTH); it does not depend on a same-cycle pop.
  - Push on cmd_valid & cmd_ready. Pop is performed only by the FSM.
  - Simultaneous push and pop leaves occupancy unchanged; data order is strict FIFO.
  - Pointers wrap modulo DEPTH. Occupancy counter is clog2(DEPTH)+1 bits.
- Select codes:
  - Mapped: 000 AND, 001 NAND, 011 OR, 111 NOR, 100 XOR, 010 XNOR, 110 ADD.
  - 101 is unmapped and illegal.
- FSM states IDLE, ISSUE, RESP:
  - IDLE: if FIFO non-empty, pop the head.
    - Legal sel: load alu_a/alu_b/alu_sel from the entry, go to ISSUE.
    - sel = 101: leave alu_* unchanged, set rsp_data = 0, rsp_err = 1, rsp_valid = 1, go to RESP.
  - ISSUE: one full cycle for the ALU to settle. At the closing edge: rsp_data = alu_c, rsp_err = 0, rsp_valid = 1, go to RESP.
  - RESP: rsp_valid, rsp_data, rsp_err held stable until rsp_ready.
    - On handshake: op_count += 1, wrapping 255 → 0.
    - If FIFO non-empty: pop and apply the IDLE pop rules in the same edge (ISSUE, or RESP for an illegal sel).
    - Otherwise: rsp_valid = 0, go to IDLE.
- Latency: a command accepted at edge N into an empty, idle block gives rsp_valid high after edge N+2. An illegal command gives rsp_valid high after edge N+1.
- Throughput: one legal command per 2 cycles with rsp_ready held high.
- alu_* registers hold their last issued values between commands.
- Arithmetic: ADD result is the ALU's 4-bit sum; carry is discarded. No width extension in this block.

Test Plan:
- Reset, then push a=4'hC, b=4'hA, sel=000 with rsp_ready=1 → alu_sel=000 one edge after acceptance; rsp_valid=1, rsp_data=4'h8, rsp_err=0 two edges after acceptance; op_count=1.
- ADD a=9, b=8 (sel=110), then OR a=5, b=2 (sel=011), then XOR a=F, b=3 (sel=100), back-to-back → responses in order 4'h1, 4'h7, 4'hC; with rsp_ready=1 a new response every 2 cycles.
- rsp_ready=0; push commands on consecutive cycles → exactly DEPTH+1 (5) accepted, then cmd_ready=0. rsp_valid and rsp_data stay stable while stalled. Releasing rsp_ready drains all 5 in order.
- Push sel=101, a=3, b=3 → response rsp_data=0, rsp_err=1 after one edge; alu_* unchanged. The following legal AND command returns rsp_err=0.
- Assert rst_n low asynchronously mid-clock during RESP with 3 entries queued → all outputs 0 immediately, cmd_ready=1. After release, no stale responses appear.
- Complete 256 responses → op_count wraps to 0. The 257th response gives op_count=1.
